// File: rtl/spi_rx_if.sv
// spi_rx_if: serial input, pop strobe and buffered-byte outputs of spi_rx.
// master drives the serial side and pops; slave is the receiver.
interface spi_rx_if;
    logic       bit_in;
    logic       en;
    logic       restart;
    logic       rd;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic [4:0] level;
    logic       overflow;

    modport master (
        output bit_in, en, restart, rd,
        input  data, data_valid, busy, level, overflow
    );

    modport slave (
        input  bit_in, en, restart, rd,
        output data, data_valid, busy, level, overflow
    );
endinterface

// File: rtl/spi_rx.sv
// spi_rx: MSB-first serial-to-parallel receiver with a popped byte buffer.
// SPI_RX_FIFO_EN selects a DEPTH-entry ring buffer; otherwise one holding register.
module spi_rx #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    spi_rx_if.slave bus
);
    logic [7:0] sr;
    logic [2:0] cnt;
    logic [7:0] byte_in;
    logic       push;
    logic       overflow;
    logic [7:0] data;

    // A byte completes only on a plain sampling edge with seven bits held
    assign byte_in = {sr[6:0], bus.bit_in};
    assign push    = bus.en && !bus.restart && (cnt == 3'd7);

    // Shift register and bit counter; restart drops the partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bus.restart) begin
            sr  <= bus.en ? {7'b0, bus.bit_in} : 8'h00;
            cnt <= bus.en ? 3'd1 : 3'd0;
        end else if (bus.en) begin
            sr  <= byte_in;
            cnt <= cnt + 3'd1;
        end
    end

    assign bus.busy     = (cnt != 3'd0);
    assign bus.data     = data;
    assign bus.overflow = overflow;

`ifdef SPI_RX_FIFO_EN
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] rp_n;
    logic [4:0]    level;
    logic [4:0]    level_n;
    logic          full;
    logic          pop;
    logic          accept;
    logic [7:0]    data_n;

    assign full   = (level == 5'(DEPTH));
    assign pop    = bus.rd && (level != 5'd0);
    assign accept = push && (!full || pop);

    // Next head: the byte being written this edge if it lands at the head
    always_comb begin
        rp_n    = pop ? rp + 1'b1 : rp;
        level_n = level + 5'(accept) - 5'(pop);
        data_n  = 8'h00;
        if (level_n != 5'd0)
            data_n = (accept && (rp_n == wp)) ? byte_in : mem[rp_n];
    end

    // Ring buffer storage has no reset; pointers and level do
    always_ff @(posedge clk) begin
        if (accept)
            mem[wp] <= byte_in;
    end

    // Pointers, occupancy, sticky overflow and registered head
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
            data     <= 8'h00;
        end else begin
            if (accept)
                wp <= wp + 1'b1;
            rp    <= rp_n;
            level <= level_n;
            data  <= data_n;
            if (push && !accept)
                overflow <= 1'b1;
        end
    end

    assign bus.level      = level;
    assign bus.data_valid = (level != 5'd0);
`else
    localparam int unused_depth = DEPTH;

    logic valid;
    logic pop;
    logic accept;

    assign pop    = bus.rd && valid;
    assign accept = push && (!valid || pop);

    // Single holding register doubles as the registered data output
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            data     <= 8'h00;
        end else begin
            if (accept) begin
                valid <= 1'b1;
                data  <= byte_in;
            end else if (pop) begin
                valid <= 1'b0;
                data  <= 8'h00;
            end
            if (push && !accept)
                overflow <= 1'b1;
        end
    end

    assign bus.level      = {4'b0, valid};
    assign bus.data_valid = valid;
`endif
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed plan plus random traffic for spi_rx, checked every edge
// against a queue-based model of the receiver.
module tb_spi_rx;
    localparam int DEPTH = 4;
`ifdef SPI_RX_FIFO_EN
    localparam int EFF = DEPTH;
`else
    localparam int EFF = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_rx_if bus ();

    spi_rx #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q [$];
    bit         bq [$];
    bit         ovf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] bits_to_byte();
        int v = 0;
        for (int i = 0; i < 8; i++)
            v = v * 2 + int'(bq[i]);
        return v[7:0];
    endfunction

    task automatic model_step(input logic r, b, e, rs, rdv);
        bit         have = 0;
        logic [7:0] nb = 8'h00;
        if (r) begin
            q.delete();
            bq.delete();
            ovf = 0;
            return;
        end
        if (e && rs) begin
            bq.delete();
            bq.push_back(b);
        end else if (e) begin
            bq.push_back(b);
            if (bq.size() == 8) begin
                nb   = bits_to_byte();
                have = 1;
                bq.delete();
            end
        end else if (rs) begin
            bq.delete();
        end
        if (rdv && q.size() > 0)
            void'(q.pop_front());
        if (have) begin
            if (q.size() < EFF)
                q.push_back(nb);
            else
                ovf = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] hd = (q.size() > 0) ? q[0] : 8'h00;
        check({tag, ".data"},  32'(bus.data),       32'(hd));
        check({tag, ".valid"}, 32'(bus.data_valid), 32'(q.size() > 0));
        check({tag, ".busy"},  32'(bus.busy),       32'(bq.size() != 0));
        check({tag, ".level"}, 32'(bus.level),      32'(q.size()));
        check({tag, ".ovf"},   32'(bus.overflow),   32'(ovf));
    endtask

    task automatic tick(input string tag, input logic r, b, e, rs, rdv);
        rst         = r;
        bus.bit_in  = b;
        bus.en      = e;
        bus.restart = rs;
        bus.rd      = rdv;
        @(posedge clk);
        model_step(r, b, e, rs, rdv);
        #1;
        check_model(tag);
    endtask

    task automatic send_bits(input string tag, input logic [7:0] v,
                             input int n, input bit rd_last);
        for (int i = 0; i < n; i++)
            tick(tag, 1'b0, v[7-i], 1'b1, 1'b0, rd_last && (i == n - 1));
    endtask

    task automatic idle(input string tag, input bit rdv);
        tick(tag, 1'b0, 1'b0, 1'b0, 1'b0, rdv);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d,
                              input logic v, input logic [4:0] lv);
        check({tag, ".xdata"},  32'(bus.data),       32'(d));
        check({tag, ".xvalid"}, 32'(bus.data_valid), 32'(v));
        check({tag, ".xlevel"}, 32'(bus.level),      32'(lv));
    endtask

    initial begin
        bus.bit_in  = 1'b0;
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        bus.rd      = 1'b0;
        ovf = 0;

        for (int i = 0; i < 2; i++)
            tick("rst", 1'b1, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        expect_out("rst", 8'h00, 1'b0, 5'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.ovf", 32'(bus.overflow), 32'd0);

        send_bits("basic", 8'h35, 8, 0);
        expect_out("basic", 8'h35, 1'b1, 5'd1);
        check("basic.busy", 32'(bus.busy), 32'd0);
        idle("basic_pop", 1);
        expect_out("basic_pop", 8'h00, 1'b0, 5'd0);

        send_bits("gap", 8'h35, 3, 0);
        check("gap.busy", 32'(bus.busy), 32'd1);
        tick("gap_rs", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("gap_rs.busy", 32'(bus.busy), 32'd0);
        send_bits("gap_cc", 8'hCC, 4, 0);
        idle("gap_hold", 0);
        send_bits("gap_cc", 8'hCC << 4, 4, 0);
        expect_out("gap", 8'hCC, 1'b1, 5'd1);
        idle("gap_pop", 1);

`ifdef SPI_RX_FIFO_EN
        for (int i = 1; i <= 5; i++)
            send_bits("ovf", 8'(i * 8'h11), 8, 0);
        check("ovf.level", 32'(bus.level), 32'd4);
        check("ovf.flag", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf.pop", 32'(bus.data), 32'(i * 8'h11));
            idle("ovf_pop", 1);
        end
        check("ovf.empty", 32'(bus.data_valid), 32'd0);

        for (int i = 1; i <= 4; i++)
            send_bits("fullrd", 8'(i * 8'h10), 8, 0);
        send_bits("fullrd", 8'h29, 8, 1);
        check("fullrd.level", 32'(bus.level), 32'd4);
        check("fullrd.ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 3; i++)
            idle("fullrd_pop", 1);
        check("fullrd.last", 32'(bus.data), 32'h29);
        idle("fullrd_pop", 1);
        check("fullrd.empty", 32'(bus.data_valid), 32'd0);
`endif

        send_bits("mid", 8'h5A, 8, 0);
        send_bits("mid", 8'h3C, 8, 0);
        send_bits("mid", 8'hF0, 5, 0);
        tick("mid_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("mid_rst", 8'h00, 1'b0, 5'd0);
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.ovf", 32'(bus.overflow), 32'd0);
        send_bits("mid_a5", 8'hA5, 8, 0);
        expect_out("mid_a5", 8'hA5, 1'b1, 5'd1);

        for (int i = 0; i < 3000; i++)
            tick("rand", ($urandom_range(0, 199) == 0),
                 1'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 5) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
